// File: rtl/music_playlist_ctrl.sv
// music_playlist_ctrl
//   Playlist sequencer in front of the music player. A play command walks
//   song ids first..last. For each song it pulses start_song with song_sel
//   held, waits for player_idle to fall and then rise again, and inserts a
//   silent gap before the next song. Supports stop, skip and loop.
//   player_abort is OR'd into the player's reset by the top level.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   play, stop, skip   one-cycle commands (priority stop > skip > play)
//   loop_en            1 = wrap last->first instead of finishing
//   first_song         playlist range, latched on an accepted play
//   last_song
//   player_idle        player idle status
//   player_song_sel    song id to player, held from one START to the next
//   player_start_song  one-cycle start pulse to player
//   player_abort       one-cycle pulse that resets the player
//   busy               high in every state except IDLE
//   cur_song           same value as player_song_sel
//   done               one-cycle pulse when the playlist finishes normally
//   err                one-cycle pulse on a start timeout
module music_playlist_ctrl #(
    parameter int NUM_SONGS     = 2,
    parameter int GAP_CYCLES    = 256,
    parameter int START_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    input  logic       stop,
    input  logic       skip,
    input  logic       loop_en,
    input  logic [4:0] first_song,
    input  logic [4:0] last_song,
    input  logic       player_idle,
    output logic [4:0] player_song_sel,
    output logic       player_start_song,
    output logic       player_abort,
    output logic       busy,
    output logic [4:0] cur_song,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_PLAY,
        S_GAP,
        S_ABORT
    } state_t;

    localparam logic [5:0]  SONG_LIMIT = 6'(NUM_SONGS);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TMO_LAST   = 16'(START_TIMEOUT - 1);
    localparam bit          GAP_EN     = (GAP_CYCLES != 0);

    state_t      state_q, state_d;
    logic [4:0]  sel_q, sel_d;       // song currently presented to the player
    logic [4:0]  next_q, next_d;     // song to start when the gap ends
    logic [4:0]  first_q, first_d;
    logic [4:0]  last_q, last_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] tmo_q, tmo_d;
    logic        skip_q, skip_d;     // ABORT was entered by skip, not stop
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        range_ok;
    logic        at_last;
    logic [4:0]  adv_song;
    logic        adv_req;            // current song is over: apply advance rules
    logic        adv_gap;            // advance through GAP (natural end / timeout)

    assign range_ok = (first_song <= last_song) && ({1'b0, last_song} < SONG_LIMIT);
    assign at_last  = (sel_q == last_q);
    assign adv_song = at_last ? first_q : sel_q + 5'd1;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        next_d  = next_q;
        first_d = first_q;
        last_d  = last_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        skip_d  = skip_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        adv_req = 1'b0;
        adv_gap = 1'b0;

        case (state_q)
            S_IDLE: begin
                // stop/skip in the same cycle swallow a play
                if (play && !stop && !skip && range_ok) begin
                    first_d = first_song;
                    last_d  = last_song;
                    sel_d   = first_song;
                    state_d = S_START;
                end
            end
            S_START: begin
                tmo_d = 16'd0;
                if (stop) begin
                    skip_d  = 1'b0;
                    state_d = S_ABORT;
                end else if (skip) begin
                    skip_d  = 1'b1;
                    state_d = S_ABORT;
                end else begin
                    state_d = S_WAIT_BUSY;
                end
            end
            S_WAIT_BUSY: begin
                if (stop) begin
                    skip_d  = 1'b0;
                    state_d = S_ABORT;
                end else if (skip) begin
                    skip_d  = 1'b1;
                    state_d = S_ABORT;
                end else if (!player_idle) begin
                    state_d = S_PLAY;
                end else if (tmo_q == TMO_LAST) begin
                    // player never went busy: flag it and move on
                    err_d   = 1'b1;
                    adv_req = 1'b1;
                    adv_gap = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_PLAY: begin
                if (stop) begin
                    skip_d  = 1'b0;
                    state_d = S_ABORT;
                end else if (skip) begin
                    skip_d  = 1'b1;
                    state_d = S_ABORT;
                end else if (player_idle) begin
                    adv_req = 1'b1;
                    adv_gap = 1'b1;
                end
            end
            S_GAP: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (skip || gap_q == GAP_LAST) begin
                    sel_d   = next_q;
                    state_d = S_START;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_ABORT: begin
                // a skipped song goes straight to the next start: the user
                // asked for the next song now, so no silent gap
                if (skip_q) adv_req = 1'b1;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (adv_req) begin
            if (at_last && !loop_en) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else if (adv_gap && GAP_EN) begin
                next_d  = adv_song;
                gap_d   = 16'd0;
                state_d = S_GAP;
            end else begin
                sel_d   = adv_song;
                state_d = S_START;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= 5'd0;
            next_q  <= 5'd0;
            first_q <= 5'd0;
            last_q  <= 5'd0;
            gap_q   <= 16'd0;
            tmo_q   <= 16'd0;
            skip_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            next_q  <= next_d;
            first_q <= first_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            skip_q  <= skip_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign player_song_sel   = sel_q;
    assign cur_song          = sel_q;
    assign player_start_song = (state_q == S_START);
    assign player_abort      = (state_q == S_ABORT);
    assign busy              = (state_q != S_IDLE);
    assign done              = done_q;
    assign err               = err_q;

endmodule
